// File: rtl/keyboard_movement_decoder.sv
// keyboard_movement_decoder: PS/2 make/break decoder driving a registered one-hot movement vector
module keyboard_movement_decoder #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] scancode,
    input  logic       scancode_valid,
    output logic       turn_right,
    output logic       turn_left,
    output logic       move_forward,
    output logic       move_backward,
    output logic       any_held
);
    localparam logic [1:0] IDLE = 2'd0, EXT = 2'd1, BRK = 2'd2, EXT_BRK = 2'd3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [1:0]       state, state_nxt, last, hit_idx;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       ext_held, pln_held, ext_nxt, pln_nxt, held, held_nxt, hit, sel;
    logic             last_vld, last_vld_nxt, is_prefix, make, brk;
    // Direction bit order: 0 forward, 1 backward, 2 right, 3 left; state[0] = E0 seen, state[1] = F0 seen
    always_comb begin
        hit = state[0] ? {scancode == 8'h6B, scancode == 8'h74, scancode == 8'h72, scancode == 8'h75}
                       : {scancode == 8'h1C, scancode == 8'h23, scancode == 8'h1B, scancode == 8'h1D};
        hit_idx = {hit[3] | hit[2], hit[3] | hit[1]};
        is_prefix = scancode == 8'hE0 || scancode == 8'hF0;
        make = scancode_valid && !state[1] && |hit;
        brk = scancode_valid && state[1] && |hit;
        ext_nxt = make && state[0] ? ext_held | hit : brk && state[0] ? ext_held & ~hit : ext_held;
        pln_nxt = make && !state[0] ? pln_held | hit : brk && !state[0] ? pln_held & ~hit : pln_held;
        held = ext_held | pln_held;
        held_nxt = ext_nxt | pln_nxt;
        last_vld_nxt = make || (last_vld && held_nxt[last]);
        state_nxt = !scancode_valid ? (state != IDLE && cnt == CNT_LAST ? IDLE : state)
                  : state == IDLE ? (scancode == 8'hE0 ? EXT : scancode == 8'hF0 ? BRK : IDLE)
                  : state == EXT ? (scancode == 8'hF0 ? EXT_BRK : scancode == 8'hE0 ? EXT : IDLE)
                  : is_prefix ? state : IDLE;
        sel = last_vld && held[last] ? 4'b0001 << last
            : held[0] ? 4'b0001 : held[1] ? 4'b0010 : held[2] ? 4'b0100 : held[3] ? 4'b1000 : 4'b0000;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            ext_held <= '0;
            pln_held <= '0;
            last <= '0;
            last_vld <= 1'b0;
            {turn_left, turn_right, move_backward, move_forward} <= 4'b0000;
            any_held <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt <= scancode_valid || state == IDLE ? '0 : cnt + CNT_W'(1);
            ext_held <= ext_nxt;
            pln_held <= pln_nxt;
            last <= make ? hit_idx : last;
            last_vld <= last_vld_nxt;
            {turn_left, turn_right, move_backward, move_forward} <= sel;
            any_held <= |held;
        end
    end
endmodule

// File: tb/tb_keyboard_movement_decoder.sv
// tb_keyboard_movement_decoder: vector table plus scoreboard queue checking the movement decoder
module tb_keyboard_movement_decoder;
    localparam int T = 16;
    typedef struct {logic [7:0] code; logic [4:0] exp;} vec_t;
    typedef struct {int due; logic [4:0] exp; logic [7:0] code;} sb_t;
    logic       clock = 1'b0, reset = 1'b0, scancode_valid = 1'b0;
    logic [7:0] scancode = 8'h00;
    logic       turn_right, turn_left, move_forward, move_backward, any_held;
    logic [4:0] outs;
    sb_t        q[$];
    vec_t       tbl [59];
    int         cycle = 0, checks = 0, failures = 0;

    keyboard_movement_decoder #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
        .clock(clock), .reset(reset), .scancode(scancode), .scancode_valid(scancode_valid),
        .turn_right(turn_right), .turn_left(turn_left), .move_forward(move_forward),
        .move_backward(move_backward), .any_held(any_held)
    );

    always #5 clock = ~clock;
    assign outs = {any_held, turn_left, turn_right, move_backward, move_forward};

    // Outputs are sampled on the falling edge; each strobe's result is due two edges later.
    initial begin
        sb_t e;
        forever begin
            @(negedge clock);
            cycle++;
            checks++;
            if ($countones(outs[3:0]) > 1) begin
                failures++;
                $display("FAIL onehot cycle=%0d got=%b required at most one bit", cycle, outs[3:0]);
            end
            if (q.size() > 0 && q[0].due == cycle) begin
                e = q.pop_front();
                checks++;
                if (outs !== e.exp) begin
                    failures++;
                    $display("FAIL byte_%h cycle=%0d got=%b required=%b", e.code, cycle, outs, e.exp);
                end
            end
        end
    end

    task automatic send(input logic [7:0] c, input logic [4:0] e);
        scancode = c;
        scancode_valid = 1'b1;
        q.push_back('{cycle + 2, e, c});
        @(negedge clock);
        #1;
        scancode_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic check_now(input string name, input logic [4:0] e);
        checks++;
        if (outs !== e) begin
            failures++;
            $display("FAIL %s got=%b required=%b", name, outs, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl = '{
            '{8'hE0, 5'b00000}, '{8'h75, 5'b10001}, '{8'hE0, 5'b10001}, '{8'hF0, 5'b10001},
            '{8'h75, 5'b00000}, '{8'h1D, 5'b10001}, '{8'h23, 5'b10100}, '{8'hF0, 5'b10100},
            '{8'h23, 5'b10001}, '{8'hE0, 5'b10001}, '{8'h75, 5'b10001}, '{8'hF0, 5'b10001},
            '{8'h1D, 5'b10001}, '{8'hE0, 5'b10001}, '{8'hF0, 5'b10001}, '{8'h75, 5'b00000},
            '{8'hE0, 5'b00000}, '{8'h6B, 5'b11000}, '{8'hE0, 5'b11000}, '{8'h72, 5'b10010},
            '{8'hE0, 5'b10010}, '{8'hF0, 5'b10010}, '{8'h72, 5'b11000}, '{8'hE0, 5'b11000},
            '{8'hF0, 5'b11000}, '{8'h6B, 5'b00000}, '{8'h1C, 5'b11000}, '{8'h1B, 5'b10010},
            '{8'hF0, 5'b10010}, '{8'h1B, 5'b11000}, '{8'h1D, 5'b10001}, '{8'hF0, 5'b10001},
            '{8'h1D, 5'b11000}, '{8'hF0, 5'b11000}, '{8'h1C, 5'b00000}, '{8'h23, 5'b10100},
            '{8'h1D, 5'b10001}, '{8'h23, 5'b10100}, '{8'hF0, 5'b10100}, '{8'h23, 5'b10001},
            '{8'hF0, 5'b10001}, '{8'h1D, 5'b00000}, '{8'h15, 5'b00000}, '{8'hF0, 5'b00000},
            '{8'h15, 5'b00000}, '{8'h1D, 5'b10001}, '{8'hF0, 5'b10001}, '{8'h1D, 5'b00000},
            '{8'hE0, 5'b00000}, '{8'hE0, 5'b00000}, '{8'h74, 5'b10100}, '{8'hE0, 5'b10100},
            '{8'hF0, 5'b10100}, '{8'hF0, 5'b10100}, '{8'h74, 5'b00000}, '{8'h1D, 5'b10001},
            '{8'hF0, 5'b10001}, '{8'hE0, 5'b10001}, '{8'h1D, 5'b00000}
        };
        idle(3);
        check_now("in_reset", 5'b00000);
        reset = 1'b1;
        idle(1);
        check_now("after_release", 5'b00000);
        for (int i = 0; i < 59; i++) send(tbl[i].code, tbl[i].exp);
        idle(3);
        // Prefix abandoned by timeout: A decodes as a plain key.
        send(8'hE0, 5'b00000);
        idle(T);
        send(8'h1C, 5'b11000);
        send(8'hF0, 5'b11000);
        send(8'h1C, 5'b00000);
        idle(3);
        // Byte on the exact timeout edge is still treated as extended, and unmapped.
        send(8'hE0, 5'b00000);
        idle(T - 1);
        send(8'h1C, 5'b00000);
        send(8'h1D, 5'b10001);
        send(8'hF0, 5'b10001);
        send(8'h1D, 5'b00000);
        idle(3);
        // Reset in the middle of a break sequence drops flags and prefix.
        send(8'h1D, 5'b10001);
        send(8'hE0, 5'b10001);
        send(8'hF0, 5'b10001);
        idle(2);
        reset = 1'b0;
        #1;
        check_now("midseq_reset_async", 5'b00000);
        idle(3);
        reset = 1'b1;
        send(8'h75, 5'b00000);
        idle(2);
        send(8'hE0, 5'b00000);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        send(8'h75, 5'b00000);
        idle(3);
        // Reset while right is held clears outputs before the next clock edge.
        send(8'hE0, 5'b00000);
        send(8'h74, 5'b10100);
        idle(2);
        check_now("right_held", 5'b10100);
        reset = 1'b0;
        #1;
        check_now("async_reset", 5'b00000);
        idle(1);
        reset = 1'b1;
        idle(3);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/keyboard_movement_decoder.md
Name: keyboard_movement_decoder

Overview:
- Sits directly upstream of the player updater.
- Consumes PS/2 scancode bytes from the keyboard receiver and tracks which movement keys are currently held, using make, break and extended-prefix sequences.
- Drives the four movement inputs (turn_right, turn_left, move_forward, move_backward) as a registered, strictly one-hot-or-zero vector. The updater only acts on exactly one asserted bit.

Parameters:
- TIMEOUT_CYCLES, 1000000: clock cycles a partial sequence (after E0 and/or F0) may wait for its next byte before being discarded.
- CNT_W, 20: width of the timeout counter. Must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset. 0 clears all state immediately.
- scancode  in  8  byte from the PS/2 receiver.
- scancode_valid  in  1  one-cycle strobe; scancode is valid in that cycle.
- turn_right  out  1  to player updater.
- turn_left  out  1  to player updater.
- move_forward  out  1  to player updater.
- move_backward  out  1  to player updater.
- any_held  out  1  high while at least one movement key is held.

Behaviour:
- Reset (reset=0, async): all outputs 0, all held flags 0, last-pressed invalid, FSM in IDLE, timeout counter 0.
- Key map:
  - Extended (E0-prefixed): 75=forward, 72=backward, 74=right, 6B=left.
  - Plain: 1D(W)=forward, 1B(S)=backward, 23(D)=right, 1C(A)=left.
  - Arrow and letter keys have separate held flags (8 flags). A direction is held if either of its flags is set.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Transitions occur only on edges where scancode_valid=1:
  - IDLE: E0->EXT; F0->BRK; mapped plain code -> set flag, stay IDLE; other byte -> ignored, stay IDLE.
  - EXT: F0->EXT_BRK; E0->stay EXT; mapped extended code -> set flag, go IDLE; other byte -> IDLE.
  - BRK: mapped plain code -> clear flag, go IDLE; E0/F0 -> stay BRK; other byte -> IDLE.
  - EXT_BRK: mapped extended code -> clear flag, go IDLE; E0/F0 -> stay; other byte -> IDLE.
- Timeout:
  - Counter resets to 0 on every valid byte and whenever in IDLE. It increments each cycle while in a non-IDLE state.
  - On reaching TIMEOUT_CYCLES-1 the FSM returns to IDLE with no flag change.
  - If a valid byte arrives in the same cycle as the timeout, the byte is processed and the timeout is ignored.
- Last-pressed tracking:
  - A make of direction d sets last=d, valid=1, even if d is already held (typematic repeat keeps it last).
  - A break that leaves direction d un-held while last=d clears valid.
- Output selection (combinational from flags/last, then registered):
  - If last is valid and still held, assert only that direction.
  - Otherwise assert the highest held direction by fixed priority: forward > backward > right > left.
  - If nothing is held, all four outputs are 0.
- Latency: the final byte of a sequence is sampled at edge k and the flags update at edge k. Outputs and any_held reflect the change after edge k+1 (2-cycle latency from the strobe).
- Invariant: at most one of the four movement outputs is 1 in any cycle, including the cycle after reset release.
- Reset asserted mid-sequence: partial prefix discarded, all flags cleared. After release the next byte is decoded from IDLE.

Test Plan:
- Reset, then E0,75 strobes -> move_forward=1 two cycles after the 75 strobe, others 0, any_held=1. Then E0,F0,75 -> all 0, any_held=0.
- Hold W (1D), then press D (23) -> turn_right=1, move_forward=0. Release D (F0,23) -> move_forward=1 again.
- Press both arrow-up (E0,75) and W (1D), release only W (F0,1D) -> move_forward stays 1 (arrow flag still set). Release arrow -> 0.
- Send E0 then idle TIMEOUT_CYCLES cycles, then 1C -> FSM has returned to IDLE, so turn_left=1 (plain A), not a stray extended decode. Same pattern with byte arriving on the exact timeout cycle -> decoded as extended 1C, ignored.
- Hold left (E0,6B) and back (E0,72) with last=back, release back -> turn_left=1. Release left -> all 0. Assert one-hot invariant every cycle.
- Mid-sequence reset: E0,F0 then reset low 3 cycles, release, send 75 -> ignored (not mapped plain), outputs stay 0. Then press-hold right, pulse reset -> outputs 0 asynchronously, before the next clock edge.
